peripheral_power_sequencer: RTL and testbench

// - Schedules power-up/power-down of NUM_PERIPH peripheral routes (clock/reset/switch/isolate chains).
// - Allows only one route to transition at a time, which limits in-rush current and switch-fabric contention.
// - Sits between software/PMU client requests and the per-peripheral route enable handshakes.
// - Grants the single transition slot round-robin.

---
 rtl/peripheral_power_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_peripheral_power_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_power_sequencer.sv
// peripheral_power_sequencer
//   Schedules power-up and power-down of NUM_PERIPH peripheral routes. Only one
//   route may be in transition at a time. The single transition slot is granted
//   round-robin, starting from the channel after the one that last finished.
//
// Ports
//   clock             in   block clock
//   async_resetn      in   asynchronous, active-low reset
//   client_req        in   per-client level request (1 = want on, 0 = want off)
//   client_ack        out  per-client registered state (1 = route fully on)
//   route_enable_req  out  registered enable to each route's enable_req
//   route_enable_ack  in   each route's enable_ack (1 = all stages ready, 0 = silent)
//   busy              out  registered; 1 while the transition slot is held
//   fault             out  sticky per-route timeout flag
//
// Optional feature: define PERIPH_SEQ_TIMEOUT_EN to add the transition timeout.
//   A transition that runs TIMEOUT_CYCLES busy cycles without completing moves
//   its channel to FAULT. Without the macro, fault is tied to 0 and a
//   transition waits indefinitely.
module peripheral_power_sequencer #(
    parameter int unsigned NUM_PERIPH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TMO_W          = 11
) (
    input  logic                  clock,
    input  logic                  async_resetn,
    input  logic [NUM_PERIPH-1:0] client_req,
    output logic [NUM_PERIPH-1:0] client_ack,
    output logic [NUM_PERIPH-1:0] route_enable_req,
    input  logic [NUM_PERIPH-1:0] route_enable_ack,
    output logic                  busy,
    output logic [NUM_PERIPH-1:0] fault
);

    localparam int unsigned PTR_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

    typedef enum logic [2:0] {
        CH_OFF,
        CH_UP,
        CH_ON,
        CH_DOWN,
        CH_FAULT
    } ch_state_e;

    ch_state_e             state_q [NUM_PERIPH];
    ch_state_e             state_d [NUM_PERIPH];
    logic [NUM_PERIPH-1:0] ack_q, ack_d;
    logic [NUM_PERIPH-1:0] req_q, req_d;
    logic                  busy_q, busy_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      act_q, act_d;     // channel currently holding the slot

    logic [NUM_PERIPH-1:0] pending;
    logic                  grant_vld;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      ptr_after_act;
    logic                  act_done;

`ifdef PERIPH_SEQ_TIMEOUT_EN
    logic [NUM_PERIPH-1:0] fault_q, fault_d;
    logic [TMO_W-1:0]      cnt_q, cnt_d;
`else
    localparam int unsigned unused_tmo_cfg = TIMEOUT_CYCLES + TMO_W;
`endif

    // A channel wants service when its client asks for the opposite of its
    // settled state. Channels that are in transition or in FAULT never qualify.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
            pending[i] = ((state_q[i] == CH_OFF) &&  client_req[i]) ||
                         ((state_q[i] == CH_ON)  && !client_req[i]);
        end
    end

    // First pending channel, scanning from ptr_q upward with wrap.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_PERIPH) begin
                idx = idx - NUM_PERIPH;
            end
            cand = PTR_W'(idx);
            if (!grant_vld && pending[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign ptr_after_act = (act_q == PTR_W'(NUM_PERIPH - 1)) ? '0 : act_q + PTR_W'(1);

    assign act_done = ((state_q[act_q] == CH_UP)   &&  route_enable_ack[act_q]) ||
                      ((state_q[act_q] == CH_DOWN) && !route_enable_ack[act_q]);

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        req_d   = req_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        act_d   = act_q;
`ifdef PERIPH_SEQ_TIMEOUT_EN
        fault_d = fault_q;
        cnt_d   = cnt_q;
`endif
        if (!busy_q) begin
            if (grant_vld) begin
                busy_d             = 1'b1;
                act_d              = grant_idx;
                req_d[grant_idx]   = ~req_q[grant_idx];
                state_d[grant_idx] = (state_q[grant_idx] == CH_OFF) ? CH_UP : CH_DOWN;
`ifdef PERIPH_SEQ_TIMEOUT_EN
                cnt_d              = '0;
`endif
            end
        end else if (act_done) begin
            // The completion edge only releases the slot; arbitration resumes
            // on the following edge, which gives the idle cycle between grants.
            state_d[act_q] = (state_q[act_q] == CH_UP) ? CH_ON : CH_OFF;
            ack_d[act_q]   = (state_q[act_q] == CH_UP);
            busy_d         = 1'b0;
            ptr_d          = ptr_after_act;
        end
`ifdef PERIPH_SEQ_TIMEOUT_EN
        // The counter reads k-1 on the k-th busy edge after the grant. It
        // therefore faults on the edge where it would reach TIMEOUT_CYCLES.
        else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            fault_d[act_q] = 1'b1;
            req_d[act_q]   = 1'b0;
            ack_d[act_q]   = 1'b0;
            state_d[act_q] = CH_FAULT;
            busy_d         = 1'b0;
            ptr_d          = ptr_after_act;
        end else begin
            cnt_d = cnt_q + TMO_W'(1);
        end

        for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
            if ((state_q[i] == CH_FAULT) && !client_req[i] && !route_enable_ack[i]) begin
                state_d[i] = CH_OFF;
                fault_d[i] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
                state_q[i] <= CH_OFF;
            end
            ack_q   <= '0;
            req_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            act_q   <= '0;
`ifdef PERIPH_SEQ_TIMEOUT_EN
            fault_q <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            act_q   <= act_d;
`ifdef PERIPH_SEQ_TIMEOUT_EN
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign client_ack       = ack_q;
    assign route_enable_req = req_q;
    assign busy             = busy_q;
`ifdef PERIPH_SEQ_TIMEOUT_EN
    assign fault            = fault_q;
`else
    assign fault            = '0;
`endif

endmodule

// File: tb/tb_peripheral_power_sequencer.sv
// tb_peripheral_power_sequencer
//   Directed bench for peripheral_power_sequencer (NUM_PERIPH = 4). It drives a
//   per-cycle vector table and then runs hand-written sequences: contention,
//   async reset during UP, and a timeout when PERIPH_SEQ_TIMEOUT_EN is defined.
module tb_peripheral_power_sequencer;

    logic       clock = 1'b0;
    logic       async_resetn = 1'b0;
    logic [3:0] client_req = '0;
    logic [3:0] client_ack;
    logic [3:0] route_enable_req;
    logic [3:0] route_enable_ack = '0;
    logic       busy;
    logic [3:0] fault;

    int total = 0;
    int bad   = 0;

    peripheral_power_sequencer #(
        .NUM_PERIPH    (4),
        .TIMEOUT_CYCLES(16),
        .TMO_W         (5)
    ) dut (
        .clock           (clock),
        .async_resetn    (async_resetn),
        .client_req      (client_req),
        .client_ack      (client_ack),
        .route_enable_req(route_enable_req),
        .route_enable_ack(route_enable_ack),
        .busy            (busy),
        .fault           (fault)
    );

    always #5 clock = ~clock;

    // Route model, updated on the falling edge. When disabled, ack follows
    // ack_force. When enabled, ack copies req model_delay falling edges after
    // the two differ.
    logic       model_en    = 1'b0;
    int         model_delay = 5;
    logic [3:0] ack_force   = '0;
    int         mcnt [4];

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (!model_en) begin
                route_enable_ack[i] = ack_force[i];
                mcnt[i] = 0;
            end else if (route_enable_req[i] != route_enable_ack[i]) begin
                mcnt[i] = mcnt[i] + 1;
                if (mcnt[i] >= model_delay) begin
                    route_enable_ack[i] = route_enable_req[i];
                    mcnt[i] = 0;
                end
            end else begin
                mcnt[i] = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] cr;   // client_req driven
        logic [3:0] ra;   // route_enable_ack driven
        logic [3:0] ca;   // expected client_ack
        logic [3:0] rr;   // expected route_enable_req
        logic       b;    // expected busy
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic [3:0] cr, input logic [3:0] ra,
                        input logic [3:0] ca, input logic [3:0] rr, input logic b);
        vec_t v;
        v.cr = cr; v.ra = ra; v.ca = ca; v.rr = rr; v.b = b;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int         order [4];
    int         gcount;
    int         multi_viol;
    int         idle_viol;
    logic       done;
    logic [3:0] prev_req;
    logic       prev_busy;
    logic [3:0] rising;

    initial begin
        // Single up/down on ch0.
        addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        addv(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0);
        addv(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0);
        addv(4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        addv(4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Round-robin: ch2 completes (ptr=3), then ch3 is served before ch0.
        addv(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        addv(4'b1101, 4'b0000, 4'b0000, 4'b0100, 1'b1);
        addv(4'b1101, 4'b0100, 4'b0100, 4'b0100, 1'b0);
        addv(4'b1101, 4'b0100, 4'b0100, 4'b1100, 1'b1);
        addv(4'b1101, 4'b1100, 4'b1100, 4'b1100, 1'b0);
        addv(4'b1101, 4'b1100, 4'b1100, 4'b1101, 1'b1);
        addv(4'b1101, 4'b1101, 4'b1101, 4'b1101, 1'b0);
        addv(4'b1101, 4'b1101, 4'b1101, 4'b1101, 1'b0);
        // ch1 request dropped mid-UP: UP finishes, then DOWN is granted.
        addv(4'b1111, 4'b1101, 4'b1101, 4'b1111, 1'b1);
        addv(4'b1101, 4'b1101, 4'b1101, 4'b1111, 1'b1);
        addv(4'b1101, 4'b1111, 4'b1111, 4'b1111, 1'b0);
        addv(4'b1101, 4'b1111, 4'b1111, 4'b1101, 1'b1);
        addv(4'b1101, 4'b1101, 4'b1101, 4'b1101, 1'b0);
        // Everything off, served in order 2, 3, 0.
        addv(4'b0000, 4'b1101, 4'b1101, 4'b1001, 1'b1);
        addv(4'b0000, 4'b1001, 4'b1001, 4'b1001, 1'b0);
        addv(4'b0000, 4'b1001, 4'b1001, 4'b0001, 1'b1);
        addv(4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b0);
        addv(4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        repeat (3) tick();
        check("reset.client_ack", 32'(client_ack), 32'h0);
        check("reset.route_req",  32'(route_enable_req), 32'h0);
        check("reset.busy",       32'(busy), 32'h0);
        check("reset.fault",      32'(fault), 32'h0);
        async_resetn = 1'b1;

        foreach (vq[i]) begin
            client_req = vq[i].cr;
            ack_force  = vq[i].ra;
            tick();
            check($sformatf("v%0d.client_ack", i), 32'(client_ack), 32'(vq[i].ca));
            check($sformatf("v%0d.route_req", i),  32'(route_enable_req), 32'(vq[i].rr));
            check($sformatf("v%0d.busy", i),       32'(busy), 32'(vq[i].b));
            check($sformatf("v%0d.fault", i),      32'(fault), 32'h0);
        end

        // Contention: all four requested together out of reset.
        async_resetn = 1'b0;
        #1;
        async_resetn = 1'b1;
        model_delay = 5;
        model_en    = 1'b1;
        client_req  = 4'b1111;
        gcount = 0; multi_viol = 0; idle_viol = 0; done = 1'b0;
        prev_req = '0; prev_busy = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if ($countones(route_enable_req ^ route_enable_ack) > 1) multi_viol++;
            rising = route_enable_req & ~prev_req;
            if (rising != 4'b0000) begin
                if (prev_busy) idle_viol++;
                for (int b = 3; b >= 0; b--) begin
                    if (rising[b] && gcount < 4) order[gcount] = b;
                end
                gcount += $countones(rising);
            end
            prev_req  = route_enable_req;
            prev_busy = busy;
            if (client_ack == 4'b1111) done = 1'b1;
        end
        check("cont.completed",  32'(done), 32'h1);
        check("cont.grants",     32'(gcount), 32'd4);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("cont.order%0d", g), 32'(order[g]), 32'(g));
        end
        check("cont.outstanding", 32'(multi_viol), 32'd0);
        check("cont.idle_gap",    32'(idle_viol), 32'd0);

        // Async reset while ch0 is powering up.
        model_en     = 1'b0;
        ack_force    = 4'b0000;
        client_req   = 4'b0001;
        async_resetn = 1'b0;
        #1;
        async_resetn = 1'b1;
        tick();
        check("rstup.route_req_pre", 32'(route_enable_req), 32'h1);
        check("rstup.busy_pre",      32'(busy), 32'h1);
        #3;
        async_resetn = 1'b0;
        #1;
        check("rstup.client_ack", 32'(client_ack), 32'h0);
        check("rstup.route_req",  32'(route_enable_req), 32'h0);
        check("rstup.busy",       32'(busy), 32'h0);
        check("rstup.fault",      32'(fault), 32'h0);
        tick();
        async_resetn = 1'b1;

`ifdef PERIPH_SEQ_TIMEOUT_EN
        // ch0 is granted, its route never acks, and it times out 16 edges
        // after the grant.
        client_req = 4'b0001;
        tick();
        check("tmo.grant_req", 32'(route_enable_req), 32'h1);
        repeat (15) tick();
        check("tmo.pre_busy",  32'(busy), 32'h1);
        check("tmo.pre_req",   32'(route_enable_req), 32'h1);
        check("tmo.pre_fault", 32'(fault), 32'h0);
        tick();
        check("tmo.fault",     32'(fault), 32'h1);
        check("tmo.req",       32'(route_enable_req), 32'h0);
        check("tmo.busy",      32'(busy), 32'h0);
        check("tmo.ack",       32'(client_ack), 32'h0);
        tick();
        check("tmo.sticky_fault", 32'(fault), 32'h1);
        check("tmo.sticky_busy",  32'(busy), 32'h0);
        client_req = 4'b0000;
        tick();
        check("tmo.cleared", 32'(fault), 32'h0);
        tick();
        check("tmo.idle_busy", 32'(busy), 32'h0);
        check("tmo.idle_req",  32'(route_enable_req), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
